// File: rtl/maze_pkg.sv
// Shared types and constants for the 32x32 block maze movement logic.
// A block index packs {row[4:0], col[4:0]}; rows are 32 blocks apart.
package maze_pkg;

   localparam int GRID_COLS = 32;
   localparam int GRID_ROWS = 32;
   localparam int BLK_W     = 10;
   localparam int ROW_W     = 5;

   localparam logic [BLK_W-1:0] PAC_START = 10'd495;

   typedef logic [BLK_W-1:0] block_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   // Joystick encoding is {up,down,left,right}, so each direction owns one bit.
   function automatic logic [3:0] dir_onehot(input dir_e d);
      logic [3:0] v;
      case (d)
         DIR_UP:    v = 4'b1000;
         DIR_DOWN:  v = 4'b0100;
         DIR_LEFT:  v = 4'b0010;
         DIR_RIGHT: v = 4'b0001;
         default:   v = 4'b0000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/maze_step_calc.sv
// Combinational single-step move calculator.
// cand is the raw neighbouring block (no wrap handling); edge_block flags
// a move that would leave the grid. Anything but a one-hot direction
// yields cand = cur so that the later commit is a no-op.
module maze_step_calc
   import maze_pkg::*;
(
   input  block_t     cur,
   input  logic [3:0] dir,
   output block_t     cand,
   output logic       edge_block
);

   localparam block_t            ROW_STEP = block_t'(GRID_COLS);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(GRID_ROWS - 1);
   localparam logic [ROW_W-1:0]  LAST_COL = ROW_W'(GRID_COLS - 1);

   logic [ROW_W-1:0] w_row;
   logic [ROW_W-1:0] w_col;

   assign w_row = cur[BLK_W-1 -: ROW_W];
   assign w_col = cur[ROW_W-1:0];

   // Decode the direction into a neighbour block and an off-grid flag.
   always_comb begin
      cand       = cur;
      edge_block = 1'b0;
      if (dir == dir_onehot(DIR_UP)) begin
         cand       = cur - ROW_STEP;
         edge_block = (w_row == 5'd0);
      end else if (dir == dir_onehot(DIR_DOWN)) begin
         cand       = cur + ROW_STEP;
         edge_block = (w_row == LAST_ROW);
      end else if (dir == dir_onehot(DIR_LEFT)) begin
         cand       = cur - 10'd1;
         edge_block = (w_col == 5'd0);
      end else if (dir == dir_onehot(DIR_RIGHT)) begin
         cand       = cur + 10'd1;
         edge_block = (w_col == LAST_COL);
      end else begin
         cand       = cur;
         edge_block = 1'b0;
      end
   end

endmodule

// File: rtl/maze_move_scheduler.sv
// Round-robin movement scheduler for Pac-Man (agent 0) and the ghosts.
// Once per move tick it walks every agent through ISSUE (wall-ROM row
// lookup) and CHECK (commit if not walled / off-grid), then pulses
// sweep_done together with a post-commit collision flag.
module maze_move_scheduler
   import maze_pkg::*;
#(
   parameter int                          NUM_AGENTS = 4,
   parameter int                          TICK_DIV   = 2**20,
   parameter logic [BLK_W*NUM_AGENTS-1:0] START_POS  = {NUM_AGENTS{PAC_START}}
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          move_en,
   input  logic [4*NUM_AGENTS-1:0]       dir_flat,
   output logic [ROW_W-1:0]              rom_addr,
   input  logic [GRID_COLS-1:0]          rom_data,
   output logic [BLK_W*NUM_AGENTS-1:0]   pos_flat,
   output logic                          busy,
   output logic                          sweep_done,
   output logic                          collision
);

   localparam int               K_W       = $clog2(NUM_AGENTS);
   localparam int               CNT_W     = $clog2(TICK_DIV);
   localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_AGENTS - 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_tick_cnt;
   logic             r_tick;
   sched_state_t     r_state;
   logic [K_W-1:0]   r_k;
   block_t           r_pos [NUM_AGENTS];
   block_t           r_cand;
   logic             r_edge;
   logic [ROW_W-1:0] r_row;
   logic             r_busy;
   logic             r_sweep_done;
   logic             r_collision;

   sched_state_t     w_state_nxt;
   logic [K_W-1:0]   w_k_nxt;
   block_t           w_pos_nxt [NUM_AGENTS];
   logic             w_hit;
   block_t           w_cur;
   logic [3:0]       w_dir;
   block_t           w_cand;
   logic             w_edge_block;
   logic             w_wall;

   // Shared step calculator, fed by the agent currently being issued.
   assign w_cur = r_pos[r_k];
   assign w_dir = dir_flat[4*r_k +: 4];

   maze_step_calc u_step (
      .cur        (w_cur),
      .dir        (w_dir),
      .cand       (w_cand),
      .edge_block (w_edge_block)
   );

   // ROM row arrives one cycle after the address, i.e. during CHECK.
   assign w_wall = rom_data[r_cand[ROW_W-1:0]];

   // Move-tick divider: counts only while enabled, emits a 1-cycle tick on wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (move_en) begin
         if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
         end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            r_tick     <= 1'b0;
         end
      end else begin
         r_tick_cnt <= r_tick_cnt;
         r_tick     <= 1'b0;
      end
   end

   // Next-state, agent index, position commit and collision detection.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_pos_nxt   = r_pos;
      w_hit       = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_tick) begin
               w_k_nxt     = '0;
               w_state_nxt = ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            w_state_nxt = CHECK;
         end
         CHECK: begin
            if (!r_edge && !w_wall) begin
               w_pos_nxt[r_k] = r_cand;
            end else begin
               w_pos_nxt[r_k] = r_pos[r_k];
            end
            if (r_k == K_LAST) begin
               w_state_nxt = DONE;
            end else begin
               w_k_nxt     = r_k + K_W'(1);
               w_state_nxt = ISSUE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Collision uses the positions as they will stand after this edge.
      for (int i = 1; i < NUM_AGENTS; i++) begin
         w_hit = w_hit | (w_pos_nxt[i] == w_pos_nxt[0]);
      end
   end

   // FSM, position and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_k          <= '0;
         r_busy       <= 1'b0;
         r_sweep_done <= 1'b0;
         r_collision  <= 1'b0;
         for (int i = 0; i < NUM_AGENTS; i++) begin
            r_pos[i] <= START_POS[BLK_W*i +: BLK_W];
         end
      end else begin
         r_state      <= w_state_nxt;
         r_k          <= w_k_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_sweep_done <= (w_state_nxt == DONE);
         r_collision  <= (w_state_nxt == DONE) && w_hit;
         r_pos        <= w_pos_nxt;
      end
   end

   // Capture candidate, edge flag and ROM row when leaving ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cand <= '0;
         r_edge <= 1'b0;
         r_row  <= '0;
      end else if (r_state == ISSUE) begin
         r_cand <= w_cand;
         r_edge <= w_edge_block;
         r_row  <= w_cand[BLK_W-1 -: ROW_W];
      end else begin
         r_cand <= r_cand;
         r_edge <= r_edge;
         r_row  <= r_row;
      end
   end

   // Row address goes out directly in ISSUE so the ROM answers in CHECK.
   assign rom_addr = (r_state == ISSUE) ? w_cand[BLK_W-1 -: ROW_W] : r_row;

   for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_pos
      assign pos_flat[BLK_W*g +: BLK_W] = r_pos[g];
   end

   assign busy       = r_busy;
   assign sweep_done = r_sweep_done;
   assign collision  = r_collision;

endmodule

// File: tb/tb_maze_move_scheduler.sv
// Directed bench for maze_move_scheduler: N=2, TICK_DIV=16, Pac-Man at 495,
// ghost starting at 480, behavioural wall ROM with a 1-cycle read.
module tb_maze_move_scheduler;
   import maze_pkg::*;

   localparam int          N     = 2;
   localparam int          TD    = 16;
   localparam logic [19:0] START = {10'd480, 10'd495};

   logic        clk = 1'b0;
   logic        reset;
   logic        move_en;
   logic [7:0]  dir_flat;
   logic [4:0]  rom_addr;
   logic [31:0] rom_data;
   logic [19:0] pos_flat;
   logic        busy;
   logic        sweep_done;
   logic        collision;

   logic [31:0] rom [32];
   int          checks = 0;
   int          errors = 0;

   maze_move_scheduler #(
      .NUM_AGENTS (N),
      .TICK_DIV   (TD),
      .START_POS  (START)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .move_en    (move_en),
      .dir_flat   (dir_flat),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .pos_flat   (pos_flat),
      .busy       (busy),
      .sweep_done (sweep_done),
      .collision  (collision)
   );

   always #5 clk = ~clk;

   // Wall ROM: one-cycle registered read.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One full sweep: wait for start, check ROM rows, latency, results, pulse end.
   task automatic do_sweep(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [9:0] e0, input logic [9:0] e1, input logic ecol,
                           input logic r1chk, input logic [4:0] erow1);
      int n;
      dir_flat = {d1, d0};
      n = 0;
      while (!busy && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check_eq({tag, "_start"}, 32'(busy), 32'd1);
      check_eq({tag, "_raddr0"}, 32'(rom_addr), 32'd15);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (r1chk) check_eq({tag, "_raddr1"}, 32'(rom_addr), 32'(erow1));
      n = 2;
      while (!sweep_done && n < 16) begin
         @(posedge clk); #1; n++;
      end
      check_eq({tag, "_lat"}, 32'(n), 32'd4);
      check_eq({tag, "_pos0"}, 32'(pos_flat[9:0]), 32'(e0));
      check_eq({tag, "_pos1"}, 32'(pos_flat[19:10]), 32'(e1));
      check_eq({tag, "_coll"}, 32'(collision), 32'(ecol));
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, 32'({sweep_done, collision, busy}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;
      for (int i = 0; i < 32; i++) rom[i] = 32'd0;
      rom[15][14] = 1'b1;
      rom_data = 32'd0;
      reset    = 1'b1;
      move_en  = 1'b1;
      dir_flat = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_pos0", 32'(pos_flat[9:0]), 32'd495);
      check_eq("rst_pos1", 32'(pos_flat[19:10]), 32'd480);
      check_eq("rst_flags", 32'({busy, sweep_done, collision}), 32'd0);
      check_eq("rst_raddr", 32'(rom_addr), 32'd0);

      // First sweep after release: 16 cycles to tick plus 5 to sweep_done.
      reset = 1'b0;
      n = 0;
      while (!sweep_done && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check_eq("first_done", 32'(n), 32'd21);
      check_eq("first_pos", 32'(pos_flat), 32'(START));
      @(posedge clk); #1;

      // Wall on the left of Pac-Man; ghost at col 0 pushes against the edge.
      do_sweep("wall", 4'b0010, 4'b0010, 10'd495, 10'd480, 1'b0, 1'b0, 5'd0);
      // Multi-hot direction is ignored.
      do_sweep("multi", 4'b0011, 4'b0000, 10'd495, 10'd480, 1'b0, 1'b1, 5'd15);
      // Open move right.
      do_sweep("open", 4'b0001, 4'b0000, 10'd496, 10'd480, 1'b0, 1'b1, 5'd15);

      // Ghost up to row 0, then right to col 31.
      for (int i = 0; i < 15; i++)
         do_sweep("up", 4'b0000, 4'b1000, 10'd496, 10'(480 - 32*(i+1)), 1'b0, 1'b1, 5'(14 - i));
      for (int i = 0; i < 31; i++)
         do_sweep("right", 4'b0000, 4'b0001, 10'd496, 10'(i + 1), 1'b0, 1'b1, 5'd0);
      do_sweep("edge_up", 4'b0000, 4'b1000, 10'd496, 10'd31, 1'b0, 1'b0, 5'd0);
      do_sweep("edge_rt", 4'b0000, 4'b0001, 10'd496, 10'd31, 1'b0, 1'b0, 5'd0);

      // Ghost down to row 15, then left to 497, then into Pac-Man.
      for (int i = 0; i < 15; i++)
         do_sweep("down", 4'b0000, 4'b0100, 10'd496, 10'(31 + 32*(i+1)), 1'b0, 1'b1, 5'(i + 1));
      for (int i = 0; i < 14; i++)
         do_sweep("left", 4'b0000, 4'b0010, 10'd496, 10'(510 - i), 1'b0, 1'b1, 5'd15);
      do_sweep("coll", 4'b0000, 4'b0010, 10'd496, 10'd496, 1'b1, 1'b1, 5'd15);

      // Pause while a sweep runs: it completes, then nothing starts.
      dir_flat = 8'd0;
      n = 0;
      while (!busy && n < 40) begin
         @(posedge clk); #1; n++;
      end
      move_en = 1'b0;
      n = 0;
      while (!sweep_done && n < 16) begin
         @(posedge clk); #1; n++;
      end
      check_eq("pause_lat", 32'(n), 32'd4);
      check_eq("pause_coll", 32'(collision), 32'd1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (busy || sweep_done) cnt++;
      end
      check_eq("pause_idle", 32'(cnt), 32'd0);
      move_en = 1'b1;

      // Reset during CHECK of agent 0 aborts the sweep.
      dir_flat = 8'b0000_0001;
      n = 0;
      while (!busy && n < 40) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_busy", 32'(busy), 32'd0);
      check_eq("mid_done", 32'(sweep_done), 32'd0);
      check_eq("mid_pos", 32'(pos_flat), 32'(START));
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (sweep_done) cnt++;
      end
      check_eq("mid_nodone", 32'(cnt), 32'd0);
      do_sweep("restart", 4'b0001, 4'b0000, 10'd496, 10'd480, 1'b0, 1'b1, 5'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
